wb_retire_stage: RTL and testbench

Parametrised writeback/retire stage for the MIPS-Lite 5-stage pipeline, sitting after the MEM stage and driving the register-file write port and the WB-to-EX forwarding path. It selects the writeback source (ALU, memory, link), registers the result, suppresses writes to r0, and keeps saturating retire statistics per instruction class. Unlike earlier simulation-only halt handling, it implements HALT as a synthesizable state machine that freezes retirement and raises a `halted` flag for the testbench to poll.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/wb_retire_stage_sat_counter.sv | 19 +
 rtl/wb_retire_stage.sv | 105 ++++++++++
 tb/tb_wb_retire_stage.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS-Lite pipeline types: writeback source select, instruction
// classes and the writeback/retire state encoding.
package mips_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    CLS_ARITH = 2'd0,
    CLS_LOGIC = 2'd1,
    CLS_MEM   = 2'd2,
    CLS_CTRL  = 2'd3
  } instr_class_e;

  typedef enum logic {
    WB_RUN    = 1'b0,
    WB_HALTED = 1'b1
  } wb_state_e;

  localparam int CLASS_W = 2;

endpackage

// File: rtl/wb_retire_stage_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/wb_retire_stage.sv
// Writeback/retire stage: selects the writeback source, registers the
// register-file write, suppresses r0 writes and keeps retire statistics.
module wb_retire_stage
  import mips_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 32,
  parameter int NUM_CLASS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            alu_result,
  input  logic [DATA_W-1:0]            mem_data,
  input  logic [DATA_W-1:0]            link_addr,
  input  logic [1:0]                   wb_sel,
  input  logic                         reg_write,
  input  logic [REG_AW-1:0]            dest_reg,
  input  logic [$clog2(NUM_CLASS)-1:0] instr_class,
  input  logic                         halt,
  output logic                         rf_we,
  output logic [REG_AW-1:0]            rf_waddr,
  output logic [DATA_W-1:0]            rf_wdata,
  output logic                         halted,
  output logic [CNT_W-1:0]             retired_total,
  output logic [NUM_CLASS*CNT_W-1:0]   retired_class
);

  wb_state_e         state_q, state_d;
  logic              retire_p0;
  logic              we_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [NUM_CLASS:0] inc_p0;  // [NUM_CLASS] feeds the total counter

  always_comb begin
    state_d   = state_q;
    retire_p0 = 1'b0;
    we_p0     = 1'b0;
    if (state_q == WB_RUN && in_valid) begin
      retire_p0 = 1'b1;
      // HALT retires but never writes, whatever reg_write says
      we_p0     = !halt && reg_write && (dest_reg != '0);
      if (halt) begin
        state_d = WB_HALTED;
      end
    end
  end

  always_comb begin
    wdata_p0 = alu_result;
    case (wb_sel_e'(wb_sel))
      WB_MEM:  wdata_p0 = mem_data;
      WB_LINK: wdata_p0 = link_addr;
      default: wdata_p0 = alu_result;
    endcase
  end

  // Out-of-range classes (non-power-of-2 configs) only reach the total
  always_comb begin
    inc_p0            = '0;
    inc_p0[NUM_CLASS] = retire_p0;
    for (int k = 0; k < NUM_CLASS; k++) begin
      if (retire_p0 && (int'(instr_class) == k)) begin
        inc_p0[k] = 1'b1;
      end
    end
  end

  // ---- stage p0 -> p1: registered writeback ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WB_RUN;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      state_q <= state_d;
      rf_we   <= we_p0;
      if (retire_p0) begin
        rf_waddr <= dest_reg;
        rf_wdata <= wdata_p0;
      end
    end
  end

  assign halted = (state_q == WB_HALTED);

  sat_counter #(.W(CNT_W)) u_total (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_p0[NUM_CLASS]),
    .count (retired_total)
  );

  for (genvar g = 0; g < NUM_CLASS; g++) begin : g_cls
    sat_counter #(.W(CNT_W)) u_cls (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_p0[g]),
      .count (retired_class[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_wb_retire_stage.sv
// Bench for wb_retire_stage: a full-width instance and a CNT_W=4 instance
// share one stimulus stream and are checked against an unbounded-count model.
module tb_wb_retire_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NC = 4;
  localparam int CB = 32;
  localparam int CS = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] alu_result, mem_data, link_addr;
  logic [1:0]    wb_sel;
  logic          reg_write;
  logic [AW-1:0] dest_reg;
  logic [1:0]    instr_class;
  logic          halt;

  logic             rf_we, halted;
  logic [AW-1:0]    rf_waddr;
  logic [DW-1:0]    rf_wdata;
  logic [CB-1:0]    retired_total;
  logic [NC*CB-1:0] retired_class;

  logic             s_rf_we, s_halted;
  logic [AW-1:0]    s_rf_waddr;
  logic [DW-1:0]    s_rf_wdata;
  logic [CS-1:0]    s_retired_total;
  logic [NC*CS-1:0] s_retired_class;

  int n_cmp;
  int n_fail;

  // reference model: plain unbounded counts, clamped only when compared
  bit          m_halted;
  bit          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  longint      m_total;
  longint      m_cls [NC];

  wb_retire_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CB), .NUM_CLASS(NC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result),
    .mem_data(mem_data), .link_addr(link_addr), .wb_sel(wb_sel),
    .reg_write(reg_write), .dest_reg(dest_reg), .instr_class(instr_class),
    .halt(halt), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .halted(halted), .retired_total(retired_total), .retired_class(retired_class)
  );

  wb_retire_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CS), .NUM_CLASS(NC)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result),
    .mem_data(mem_data), .link_addr(link_addr), .wb_sel(wb_sel),
    .reg_write(reg_write), .dest_reg(dest_reg), .instr_class(instr_class),
    .halt(halt), .rf_we(s_rf_we), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata),
    .halted(s_halted), .retired_total(s_retired_total), .retired_class(s_retired_class)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic longint cap(longint v, int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  // advance one clock; the model consumes the same inputs the DUTs sampled
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_halted = 0; m_we = 0; m_waddr = '0; m_wdata = '0; m_total = 0;
      for (int k = 0; k < NC; k++) m_cls[k] = 0;
    end else if (!m_halted && in_valid) begin
      m_total++;
      m_cls[instr_class]++;
      m_waddr = dest_reg;
      m_wdata = (wb_sel == 2'd1) ? mem_data : (wb_sel == 2'd2) ? link_addr : alu_result;
      m_we    = !halt && reg_write && (dest_reg != 0);
      if (halt) m_halted = 1;
    end else begin
      m_we = 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; in_valid = 0; alu_result = '0; mem_data = '0; link_addr = '0;
    wb_sel = 0; reg_write = 0; dest_reg = '0; instr_class = 0; halt = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic drive(input logic [1:0] sel, input logic [DW-1:0] val,
                       input logic wr, input logic [AW-1:0] dst,
                       input logic [1:0] cls, input logic hlt);
    in_valid = 1; wb_sel = sel; reg_write = wr; dest_reg = dst;
    instr_class = cls; halt = hlt;
    alu_result = val; mem_data = ~val; link_addr = val ^ 32'h0000_0100;
    if (sel == 2'd1) mem_data = val;
    if (sel == 2'd2) link_addr = val;
    step();
    in_valid = 0; halt = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    in_valid = 1; reg_write = 1; dest_reg = 5'd3; alu_result = 32'h55;
    rst = 1;
    step();
    rst = 0; in_valid = 0;
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, halted} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%0b waddr=%0d wdata=%h halted=%0b, want all 0",
               rf_we, rf_waddr, rf_wdata, halted);
    end
    n_cmp++;
    if (retired_total !== '0 || retired_class !== '0 || s_retired_total !== '0) begin
      n_fail++;
      $display("FAIL reset_counters: got total=%0d class=%h small=%0d, want 0",
               retired_total, retired_class, s_retired_total);
    end
  endtask

  task automatic test_mux();
    do_reset();
    drive(2'd0, 32'h0000_0042, 1, 5'd5, 0, 0);
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h42 || retired_total !== 32'd1) begin
      n_fail++;
      $display("FAIL mux_alu: got we=%0b waddr=%0d wdata=%h total=%0d, want 1 5 00000042 1",
               rf_we, rf_waddr, rf_wdata, retired_total);
    end
    drive(2'd1, 32'hDEAD_BEEF, 1, 5'd9, 2, 0);
    n_cmp++;
    if (rf_wdata !== 32'hDEAD_BEEF || rf_waddr !== 5'd9) begin
      n_fail++;
      $display("FAIL mux_mem: got wdata=%h waddr=%0d, want deadbeef 9", rf_wdata, rf_waddr);
    end
    drive(2'd2, 32'h0000_0104, 1, 5'd31, 3, 0);
    n_cmp++;
    if (rf_wdata !== 32'h0000_0104 || rf_waddr !== 5'd31) begin
      n_fail++;
      $display("FAIL mux_link: got wdata=%h waddr=%0d, want 00000104 31", rf_wdata, rf_waddr);
    end
    drive(2'd3, 32'h0000_0007, 1, 5'd4, 0, 0);
    n_cmp++;
    if (rf_wdata !== 32'h7 || rf_we !== 1'b1) begin
      n_fail++;
      $display("FAIL mux_rsvd: got wdata=%h we=%0b, want 00000007 1", rf_wdata, rf_we);
    end
  endtask

  task automatic test_r0_bubble();
    do_reset();
    drive(2'd0, 32'h1234_5678, 1, 5'd0, 1, 0);
    n_cmp++;
    if (rf_we !== 1'b0 || retired_total !== 32'd1 || rf_wdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL r0_write: got we=%0b total=%0d wdata=%h, want 0 1 12345678",
               rf_we, retired_total, rf_wdata);
    end
    alu_result = 32'hFFFF_0000; dest_reg = 5'd7; reg_write = 1; in_valid = 0;
    step();
    n_cmp++;
    if (rf_we !== 1'b0 || retired_total !== 32'd1 || rf_waddr !== 5'd0 ||
        rf_wdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL bubble: got we=%0b total=%0d waddr=%0d wdata=%h, want 0 1 0 12345678",
               rf_we, retired_total, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_halt();
    int writes_after;
    do_reset();
    drive(2'd0, 32'h11, 1, 5'd1, 0, 0);
    drive(2'd0, 32'h22, 1, 5'd2, 2, 0);
    drive(2'd0, 32'h33, 1, 5'd3, 2, 0);
    drive(2'd0, 32'h44, 1, 5'd4, 3, 1);
    n_cmp++;
    if (halted !== 1'b1 || rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_entry: got halted=%0b we=%0b, want 1 0", halted, rf_we);
    end
    writes_after = 0;
    for (int i = 0; i < 5; i++) begin
      drive(2'd0, 32'h100 + i, 1, 5'(10 + i), 0, 0);
      if (rf_we !== 1'b0) writes_after++;
    end
    n_cmp++;
    if (writes_after != 0 || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_freeze: got %0d writes halted=%0b, want 0 writes halted=1",
               writes_after, halted);
    end
    n_cmp++;
    if (retired_total !== 32'd4 || retired_class !== {32'd1, 32'd2, 32'd0, 32'd1}) begin
      n_fail++;
      $display("FAIL halt_counts: got total=%0d class=%h, want 4 {1,0,2,1}",
               retired_total, retired_class);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 20; i++) drive(2'd0, 32'(i), 1, 5'd6, 1, 0);
    n_cmp++;
    if (s_retired_total !== 4'd15 || s_retired_class !== {4'd0, 4'd0, 4'd15, 4'd0}) begin
      n_fail++;
      $display("FAIL saturate_small: got total=%0d class=%h, want 15 class1=15 others 0",
               s_retired_total, s_retired_class);
    end
    n_cmp++;
    if (retired_total !== 32'd20 || retired_class[CB +: CB] !== 32'd20) begin
      n_fail++;
      $display("FAIL saturate_wide: got total=%0d class1=%0d, want 20 20",
               retired_total, retired_class[CB +: CB]);
    end
  endtask

  task automatic test_reset_priority();
    do_reset();
    drive(2'd0, 32'h9, 1, 5'd2, 0, 1);
    idle_inputs();
    in_valid = 1; reg_write = 1; dest_reg = 5'd3; alu_result = 32'hABCD; halt = 1;
    rst = 1;
    step();
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, halted} !== '0 || retired_total !== '0) begin
      n_fail++;
      $display("FAIL rst_priority: got we=%0b waddr=%0d wdata=%h halted=%0b total=%0d, want 0",
               rf_we, rf_waddr, rf_wdata, halted, retired_total);
    end
    rst = 0;
    drive(2'd0, 32'h77, 1, 5'd8, 2, 0);
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h77 ||
        retired_total !== 32'd1 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_resume: got we=%0b waddr=%0d wdata=%h total=%0d halted=%0b, want 1 8 77 1 0",
               rf_we, rf_waddr, rf_wdata, retired_total, halted);
    end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 79) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      wb_sel      = 2'($urandom_range(0, 3));
      alu_result  = $urandom;
      mem_data    = $urandom;
      link_addr   = $urandom;
      reg_write   = ($urandom_range(0, 3) != 0);
      dest_reg    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      instr_class = 2'($urandom_range(0, 3));
      halt        = ($urandom_range(0, 49) == 0);
      step();
      n_cmp++;
      if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata ||
          halted !== m_halted || retired_total !== CB'(cap(m_total, CB)) ||
          s_retired_total !== CS'(cap(m_total, CS))) begin
        n_fail++;
        bad++;
        if (bad <= 5)
          $display("FAIL random_%0d: got we=%0b a=%0d d=%h h=%0b tot=%0d stot=%0d, want %0b %0d %h %0b %0d %0d",
                   i, rf_we, rf_waddr, rf_wdata, halted, retired_total, s_retired_total,
                   m_we, m_waddr, m_wdata, m_halted, cap(m_total, CB), cap(m_total, CS));
      end
      for (int k = 0; k < NC; k++) begin
        n_cmp++;
        if (retired_class[k*CB +: CB] !== CB'(cap(m_cls[k], CB)) ||
            s_retired_class[k*CS +: CS] !== CS'(cap(m_cls[k], CS))) begin
          n_fail++;
          bad++;
          if (bad <= 5)
            $display("FAIL random_class%0d_%0d: got %0d/%0d, want %0d/%0d", k, i,
                     retired_class[k*CB +: CB], s_retired_class[k*CS +: CS],
                     cap(m_cls[k], CB), cap(m_cls[k], CS));
        end
      end
    end
    rst = 0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    idle_inputs();
    test_reset();
    test_mux();
    test_r0_bubble();
    test_halt();
    test_saturate();
    test_reset_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
